// File: rtl/fifo_clkdiv_top.sv
// -----------------------------------------------------------------------------
// fifo_clkdiv_top
//
// Single-clock FIFO with a built-in rate divider. Two free-running counters
// produce a write tick every WDIV cycles and a read tick every RDIV cycles;
// the FIFO only honours winc/rinc on their respective ticks. Status flags and
// read data are registered.
//
// Optional feature macro: FIFO_ERR_FLAGS_EN
//   When defined, sticky ovf/udf outputs flag blocked writes/reads until reset.
//
// Ports:
//   clk    in   1      system clock, all state updates on rising edge
//   rst_n  in   1      synchronous reset, ACTIVE-HIGH (1 = reset) despite name
//   wdata  in   DSIZE  write data
//   winc   in   1      write request, level-sampled on write ticks
//   rinc   in   1      read request, level-sampled on read ticks
//   rdata  out  DSIZE  last popped word (registered)
//   full   out  1      FIFO holds 2^ASIZE words
//   empty  out  1      FIFO holds 0 words
//   ovf    out  1      sticky overflow  (FIFO_ERR_FLAGS_EN only)
//   udf    out  1      sticky underflow (FIFO_ERR_FLAGS_EN only)
// -----------------------------------------------------------------------------
module fifo_clkdiv_top #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 4,
    parameter int WDIV  = 1,
    parameter int RDIV  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] wdata,
    input  logic             winc,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             full,
`ifdef FIFO_ERR_FLAGS_EN
    output logic             empty,
    output logic             ovf,
    output logic             udf
`else
    output logic             empty
`endif
);

    localparam int DEPTH = 1 << ASIZE;
    // Counter widths never drop below one bit so DIV=1 still has a legal flop.
    localparam int WCW = (WDIV > 1) ? $clog2(WDIV) : 1;
    localparam int RCW = (RDIV > 1) ? $clog2(RDIV) : 1;

    localparam logic [WCW-1:0]   WCNT_LAST = WCW'(WDIV - 1);
    localparam logic [RCW-1:0]   RCNT_LAST = RCW'(RDIV - 1);
    localparam logic [WCW-1:0]   WCNT_ONE  = WCW'(1);
    localparam logic [RCW-1:0]   RCNT_ONE  = RCW'(1);
    localparam logic [ASIZE-1:0] PTR_ONE   = ASIZE'(1);
    localparam logic [ASIZE:0]   CNT_ONE   = (ASIZE + 1)'(1);
    localparam logic [ASIZE:0]   CNT_FULL  = (ASIZE + 1)'(DEPTH);

    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [RCW-1:0]   rcnt_q, rcnt_d;
    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic [DSIZE-1:0] rdata_q, rdata_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [DSIZE-1:0] mem_q [DEPTH];

    logic wtick_s, rtick_s;
    logic wr_en_s, rd_en_s;

    // Ticks fire while the counter sits at zero, so the first cycle after
    // reset is a tick and DIV=1 keeps the tick permanently high.
    assign wtick_s = (wcnt_q == {WCW{1'b0}});
    assign rtick_s = (rcnt_q == {RCW{1'b0}});

    // Acceptance uses the registered (pre-edge) flags.
    assign wr_en_s = wtick_s & winc & ~full_q;
    assign rd_en_s = rtick_s & rinc & ~empty_q;

    // Divider counters: count 0..DIV-1 and wrap.
    always_comb begin
        wcnt_d = wcnt_q;
        rcnt_d = rcnt_q;
        if (wcnt_q == WCNT_LAST) begin
            wcnt_d = {WCW{1'b0}};
        end else begin
            wcnt_d = wcnt_q + WCNT_ONE;
        end
        if (rcnt_q == RCNT_LAST) begin
            rcnt_d = {RCW{1'b0}};
        end else begin
            rcnt_d = rcnt_q + RCNT_ONE;
        end
    end

    // FIFO next-state: pointers, occupancy, read data and flags.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        rdata_d = rdata_q;
        if (wr_en_s) begin
            wptr_d = wptr_q + PTR_ONE;
        end else begin
            wptr_d = wptr_q;
        end
        if (rd_en_s) begin
            rptr_d  = rptr_q + PTR_ONE;
            rdata_d = mem_q[rptr_q];
        end else begin
            rptr_d  = rptr_q;
            rdata_d = rdata_q;
        end
        case ({wr_en_s, rd_en_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        // Flags come from the next-state count so they are exact after the edge.
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == {(ASIZE + 1){1'b0}});
    end

    // Control state register; rst_n is an active-high synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wcnt_q  <= {WCW{1'b0}};
            rcnt_q  <= {RCW{1'b0}};
            wptr_q  <= {ASIZE{1'b0}};
            rptr_q  <= {ASIZE{1'b0}};
            count_q <= {(ASIZE + 1){1'b0}};
            rdata_q <= {DSIZE{1'b0}};
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wcnt_q  <= wcnt_d;
            rcnt_q  <= rcnt_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            rdata_q <= rdata_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage array is deliberately not reset; writes are suppressed in reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst_n) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    assign rdata = rdata_q;
    assign full  = full_q;
    assign empty = empty_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky error flags: set on any blocked request, cleared only by reset.
    always_comb begin
        ovf_d = ovf_q | (wtick_s & winc & full_q);
        udf_d = udf_q | (rtick_s & rinc & empty_q);
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign ovf = ovf_q;
    assign udf = udf_q;
`endif

endmodule

// File: tb/tb_fifo_clkdiv_top.sv
// Bench for fifo_clkdiv_top: two instances (divide 1/1 and 3/2) share the same
// stimulus. A list-based model tracks each instance and a monitor compares all
// outputs every cycle; directed sections add literal expectations.
module tb_fifo_clkdiv_top;

    localparam int WDIV_B = 3;
    localparam int RDIV_B = 2;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic [7:0] wdata = 8'h00;

    logic [7:0] rdata_a, rdata_b;
    logic       full_a, full_b, empty_a, empty_b;
`ifdef FIFO_ERR_FLAGS_EN
    logic       ovf_a, udf_a, ovf_b, udf_b;
`endif

    always #5 clk = ~clk;

    fifo_clkdiv_top #(.DSIZE(8), .ASIZE(4), .WDIV(1), .RDIV(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
        .rdata(rdata_a), .full(full_a),
`ifdef FIFO_ERR_FLAGS_EN
        .empty(empty_a), .ovf(ovf_a), .udf(udf_a)
`else
        .empty(empty_a)
`endif
    );

    fifo_clkdiv_top #(.DSIZE(8), .ASIZE(4), .WDIV(WDIV_B), .RDIV(RDIV_B)) dut_b (
        .clk(clk), .rst_n(rst_n), .wdata(wdata), .winc(winc), .rinc(rinc),
        .rdata(rdata_b), .full(full_b),
`ifdef FIFO_ERR_FLAGS_EN
        .empty(empty_b), .ovf(ovf_b), .udf(udf_b)
`else
        .empty(empty_b)
`endif
    );

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total = checks_total + 1;
        if (act === exp) begin
            checks_passed = checks_passed + 1;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each FIFO is an ordered list: element 0 is the oldest word.
    int         wdiv [2] = '{1, WDIV_B};
    int         rdiv [2] = '{1, RDIV_B};
    int         mcnt [2];
    int         mcyc [2];
    logic [7:0] mlist [2][16];
    logic [7:0] mrd  [2];
    bit         movf [2];
    bit         mudf [2];
    bit         armed = 1'b0;
    bit         s_valid = 1'b0;
    logic       s_rst, s_winc, s_rinc;
    logic [7:0] s_wdata;

    // Capture what the DUTs see at each rising edge.
    initial forever begin
        @(posedge clk);
        s_rst   = rst_n;
        s_winc  = winc;
        s_rinc  = rinc;
        s_wdata = wdata;
        s_valid = 1'b1;
    end

    // Advance the model by one edge, then compare at the falling edge.
    initial forever begin
        @(negedge clk);
        if (s_valid) begin
            for (int k = 0; k < 2; k++) begin
                if (s_rst) begin
                    mcnt[k] = 0; mcyc[k] = 0; mrd[k] = 8'h00;
                    movf[k] = 1'b0; mudf[k] = 1'b0;
                end else begin
                    bit wt, rt, was_full, was_empty;
                    wt = (mcyc[k] % wdiv[k]) == 0;
                    rt = (mcyc[k] % rdiv[k]) == 0;
                    was_full  = (mcnt[k] == 16);
                    was_empty = (mcnt[k] == 0);
                    if (wt && s_winc && was_full)  movf[k] = 1'b1;
                    if (rt && s_rinc && was_empty) mudf[k] = 1'b1;
                    if (rt && s_rinc && !was_empty) begin
                        mrd[k] = mlist[k][0];
                        for (int j = 0; j < 15; j++) mlist[k][j] = mlist[k][j+1];
                        mcnt[k] = mcnt[k] - 1;
                    end
                    if (wt && s_winc && !was_full) begin
                        mlist[k][mcnt[k]] = s_wdata;
                        mcnt[k] = mcnt[k] + 1;
                    end
                    mcyc[k] = mcyc[k] + 1;
                end
            end
            if (s_rst) armed = 1'b1;
        end
        if (armed) begin
            chk("a_rdata", {24'h0, rdata_a}, {24'h0, mrd[0]});
            chk("a_full",  {31'h0, full_a},  {31'h0, mcnt[0] == 16});
            chk("a_empty", {31'h0, empty_a}, {31'h0, mcnt[0] == 0});
            chk("b_rdata", {24'h0, rdata_b}, {24'h0, mrd[1]});
            chk("b_full",  {31'h0, full_b},  {31'h0, mcnt[1] == 16});
            chk("b_empty", {31'h0, empty_b}, {31'h0, mcnt[1] == 0});
`ifdef FIFO_ERR_FLAGS_EN
            chk("a_ovf", {31'h0, ovf_a}, {31'h0, movf[0]});
            chk("a_udf", {31'h0, udf_a}, {31'h0, mudf[0]});
            chk("b_ovf", {31'h0, ovf_b}, {31'h0, movf[1]});
            chk("b_udf", {31'h0, udf_b}, {31'h0, mudf[1]});
`endif
        end
    end

    // Apply inputs, let one edge consume them, return just after the
    // following falling edge (after the monitor has run).
    task automatic step(input logic wi, input logic ri, input logic [7:0] wd);
        winc  = wi;
        rinc  = ri;
        wdata = wd;
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        step(1'b1, 1'b1, 8'hFF);
        rst_n = 1'b0;
    endtask

    logic [7:0] pat [8] = '{8'h3, 8'h9, 8'hD, 8'h5, 8'h1, 8'h6, 8'hD, 8'hC};

    initial begin
        @(negedge clk);
        #1;
        do_reset();
        chk("rst_empty", {31'h0, empty_a}, 32'd1);
        chk("rst_full",  {31'h0, full_a},  32'd0);
        chk("rst_rdata", {24'h0, rdata_a}, 32'd0);

        // Eight spaced single-cycle writes.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0, pat[i]);
            if (i == 0) chk("wr1_empty", {31'h0, empty_a}, 32'd0);
            chk("wr_full", {31'h0, full_a}, 32'd0);
            step(1'b0, 1'b0, 8'h00);
        end
        // Eight spaced single-cycle reads.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("rd_seq", {24'h0, rdata_a}, {24'h0, pat[i]});
            step(1'b0, 1'b0, 8'h00);
        end
        chk("rd8_empty", {31'h0, empty_a}, 32'd1);

        // Overfill: 19 writes.
        for (int i = 0; i < 19; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 14) chk("wr15_full", {31'h0, full_a}, 32'd0);
            if (i == 15) chk("wr16_full", {31'h0, full_a}, 32'd1);
        end
        chk("ovr_full", {31'h0, full_a}, 32'd1);
`ifdef FIFO_ERR_FLAGS_EN
        chk("ovf_set", {31'h0, ovf_a}, 32'd1);
`endif
        // Overdrain: 19 reads.
        for (int i = 0; i < 19; i++) begin
            step(1'b0, 1'b1, 8'h00);
            chk("drain_rdata", {24'h0, rdata_a}, (i < 16) ? i : 32'h0F);
            if (i == 15) chk("rd16_empty", {31'h0, empty_a}, 32'd1);
        end
`ifdef FIFO_ERR_FLAGS_EN
        chk("udf_set", {31'h0, udf_a}, 32'd1);
`endif

        // Four stored, then simultaneous read/write for 10 cycles.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b1, 8'(8'h50 + i));
            chk("rw_rdata", {24'h0, rdata_a}, (i < 4) ? (32'h40 + i) : (32'h50 + i - 4));
        end
        chk("rw_model_cnt", mcnt[0], 32'd4);
        chk("rw_full", {31'h0, full_a}, 32'd0);

        // Divided instance: winc held for 9 cycles -> 3 writes at 3:1.
        do_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'hA5);
        chk("div_model_cnt_b", mcnt[1], 32'd3);
        chk("div_model_cnt_a", mcnt[0], 32'd9);
        chk("div_empty_b", {31'h0, empty_b}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00);
        chk("div_rdata_b", {24'h0, rdata_b}, 32'hA5);
        // Reset in the middle of a burst.
        rst_n = 1'b1;
        step(1'b1, 1'b1, 8'h77);
        rst_n = 1'b0;
        chk("mid_rst_empty", {31'h0, empty_b}, 32'd1);
        chk("mid_rst_full",  {31'h0, full_b},  32'd0);
        chk("mid_rst_rdata", {24'h0, rdata_b}, 32'd0);
        chk("mid_rst_rdata_a", {24'h0, rdata_a}, 32'd0);

        // Randomised traffic with varying write/read bias and rare resets.
        for (int blk = 0; blk < 12; blk++) begin
            int wp, rp;
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int i = 0; i < 200; i++) begin
                rst_n = ($urandom_range(0, 299) == 0);
                step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, 8'($urandom));
            end
            rst_n = 1'b0;
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
